// File: rtl/modular_inverse.sv
// Sequential modular inverter: a^-1 mod Q computed as a^(Q-2) mod Q by
// left-to-right square-and-multiply over one shared modular multiplier.

module mod_mult #(
    parameter int LOGQ = 17,
    parameter int Q    = 65537
) (
    input  logic [LOGQ-1:0] x,
    input  logic [LOGQ-1:0] y,
    output logic [LOGQ-1:0] p
);
    localparam int W2 = 2 * LOGQ;
    localparam int WT = W2 + LOGQ + 1;
    localparam logic [W2:0]   TWO_POW = {1'b1, {W2{1'b0}}};
    localparam logic [W2:0]   MU_FULL = TWO_POW / (W2 + 1)'(Q);
    localparam logic [LOGQ:0] MU      = (LOGQ + 1)'(MU_FULL);
    localparam logic [W2-1:0] Q_W     = W2'(Q);

    logic [W2-1:0]   prod;
    logic [WT-1:0]   scaled;
    logic [LOGQ:0]   q_est;
    logic [W2-1:0]   qq;
    logic [W2-1:0]   rem0;
    logic [W2-1:0]   rem1;
    logic [W2-1:0]   rem2;

    // Barrett reduction: the quotient estimate undershoots by at most two,
    // so two conditional subtractions bring the remainder below Q.
    always_comb begin
        prod   = W2'(x) * W2'(y);
        scaled = WT'(prod) * WT'(MU);
        q_est  = (LOGQ + 1)'(scaled >> W2);
        qq     = W2'(q_est) * Q_W;
        rem0   = prod - qq;
        rem1   = (rem0 >= Q_W) ? rem0 - Q_W : rem0;
        rem2   = (rem1 >= Q_W) ? rem1 - Q_W : rem1;
        p      = LOGQ'(rem2);
    end
endmodule

module modular_inverse #(
    parameter int LOGQ = 17,
    parameter int Q    = 65537
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [LOGQ-1:0] a,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LOGQ-1:0] inv,
    output logic            err
);
    localparam int IW = $clog2(LOGQ);
    localparam logic [LOGQ-1:0] Q_L = LOGQ'(Q);
    localparam logic [LOGQ-1:0] E   = LOGQ'(Q - 2);

    typedef enum logic [1:0] {
        IDLE,
        SQ,
        MUL,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [LOGQ-1:0] a_r;
    logic [LOGQ-1:0] r;
    logic [LOGQ-1:0] mul_y;
    logic [LOGQ-1:0] prod;
    logic [IW-1:0]   i;
    logic            err_r;
    logic            operand_bad;
    logic            last_bit;

    assign operand_bad = (a == '0) || (a >= Q_L);
    assign last_bit    = (i == '0);
    assign mul_y       = (state == MUL) ? a_r : r;

    mod_mult #(
        .LOGQ (LOGQ),
        .Q    (Q)
    ) u_mul (
        .x (r),
        .y (mul_y),
        .p (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (in_valid) state_next = operand_bad ? DONE : SQ;
            SQ: begin
                if (E[i])          state_next = MUL;
                else if (last_bit) state_next = DONE;
            end
            MUL:  state_next = last_bit ? DONE : SQ;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: r holds the running power; i walks the exponent MSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            r     <= '0;
            i     <= '0;
            err_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r <= a;
                        if (operand_bad) begin
                            r     <= '0;
                            err_r <= 1'b1;
                        end else begin
                            r     <= {{(LOGQ-1){1'b0}}, 1'b1};
                            i     <= IW'(LOGQ - 1);
                            err_r <= 1'b0;
                        end
                    end
                end
                SQ: begin
                    r <= prod;
                    if (!E[i] && !last_bit) i <= i - 1'b1;
                end
                MUL: begin
                    r <= prod;
                    if (!last_bit) i <= i - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        inv       = r;
        err       = err_r;
    end
endmodule

// File: tb/tb_modular_inverse.sv
// Scoreboard bench for modular_inverse: stimulus queues expected results,
// a negedge monitor checks latency, result, hold stability and handshakes.

module tb_modular_inverse;
    localparam int LOGQ      = 17;
    localparam int Q         = 65537;
    localparam int LAT_VALID = 33;

    typedef struct {
        logic [LOGQ-1:0] inv;
        logic            err;
        int              lat;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [LOGQ-1:0] a = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [LOGQ-1:0] inv;
    logic            err;

    logic ready_level = 1'b1;
    logic rand_ready  = 1'b0;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    modular_inverse #(
        .LOGQ (LOGQ),
        .Q    (Q)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inv       (inv),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: either a fixed level set by the stimulus or a coin flip per cycle.
    always begin
        @(posedge clk);
        #1;
        out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : ready_level;
    end

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic longint model_inv(input longint x);
        longint res  = 1;
        longint base = x % Q;
        longint e    = Q - 2;
        while (e > 0) begin
            if ((e & 1) == 1) res = (res * base) % Q;
            base = (base * base) % Q;
            e    = e >> 1;
        end
        return res;
    endfunction

    task automatic check_output(input string tag);
        chk({tag, " in_ready"}, in_ready, 1);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " inv"}, inv, 0);
        chk({tag, " err"}, err, 0);
    endtask

    // Called in the posedge+1 phase; returns in the same phase after the accept edge.
    task automatic apply_stimulus(input logic [LOGQ-1:0] val,
                                  input logic [LOGQ-1:0] e_inv,
                                  input logic            e_err);
        int   waited = 0;
        exp_t ent;
        while (!in_ready && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            chk("in_ready wait", in_ready, 1);
            return;
        end
        in_valid = 1'b1;
        a        = val;
        ent.inv  = e_inv;
        ent.err  = e_err;
        ent.lat  = e_err ? 0 : LAT_VALID;
        sb_q.push_back(ent);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (sb_q.size() != 0 && waited < 2000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("drain pending", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: latency counts edges from the accept edge to the edge that raises
    // out_valid; an invalid operand reaches DONE on the accept edge itself.
    int              acc_cyc = 0;
    logic            prev_ov = 1'b0;
    logic            after_xfer = 1'b0;
    logic [LOGQ-1:0] hold_inv = '0;
    logic            hold_err = 1'b0;
    exp_t            cur;

    always @(negedge clk) begin
        if (rst) begin
            prev_ov    = 1'b0;
            after_xfer = 1'b0;
        end else begin
            if (after_xfer) begin
                chk("in_ready after transfer", in_ready, 1);
                after_xfer = 1'b0;
            end
            if (in_valid && in_ready) acc_cyc = cyc + 1;
            if (out_valid) begin
                if (!prev_ov) begin
                    hold_inv = inv;
                    hold_err = err;
                    chk("result pending at out_valid", (sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) chk("latency", cyc - acc_cyc, sb_q[0].lat);
                end else begin
                    chk("inv stable", inv, hold_inv);
                    chk("err stable", err, hold_err);
                end
                chk("in_ready during out_valid", in_ready, 0);
                if (out_ready) begin
                    if (sb_q.size() > 0) begin
                        cur = sb_q.pop_front();
                        chk("inv", inv, cur.inv);
                        chk("err", err, cur.err);
                    end
                    after_xfer = 1'b1;
                end
            end
            prev_ov = out_valid && !out_ready;
        end
    end

    initial begin
        int waited;
        logic [LOGQ-1:0] v;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_output("reset");
        repeat (3) @(posedge clk);
        #1;
        check_output("idle");

        // Reset in the middle of a computation must discard it silently.
        apply_stimulus(17'd7, 17'd0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        check_output("mid-SQ reset");
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        apply_stimulus(17'd2, 17'd32769, 1'b0);
        drain();

        apply_stimulus(17'd1, 17'd1, 1'b0);
        apply_stimulus(17'd2, 17'd32769, 1'b0);
        apply_stimulus(17'd3, 17'd21846, 1'b0);
        apply_stimulus(17'd65536, 17'd65536, 1'b0);
        apply_stimulus(17'd0, 17'd0, 1'b1);
        apply_stimulus(17'd65537, 17'd0, 1'b1);
        apply_stimulus(17'd131071, 17'd0, 1'b1);
        drain();

        // Backpressure: 5 * 26215 = 131075 = 2*65537 + 1.
        ready_level = 1'b0;
        apply_stimulus(17'd5, 17'd26215, 1'b0);
        waited = 0;
        while (!out_valid && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("out_valid under backpressure", out_valid, 1);
        repeat (6) @(posedge clk);
        #1;
        ready_level = 1'b1;
        drain();

        // Input offered while busy must be ignored until IDLE.
        apply_stimulus(17'd3, 17'd21846, 1'b0);
        in_valid = 1'b1;
        a        = 17'd2;
        repeat (20) @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        rand_ready = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            v = LOGQ'($urandom_range(1, Q - 1));
            apply_stimulus(v, LOGQ'(model_inv(longint'(v))), 1'b0);
        end
        drain();
        rand_ready = 1'b0;

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
